// File: rtl/i2s_frame_tx.sv
// rtl/i2s_frame_tx.sv - I2S bit/word clock generator and stereo frame serialiser
// Optional: I2S_TX_REPEAT_ON_UNDERRUN_EN repeats the last loaded frame on underrun.
module i2s_frame_tx #(
    parameter int CLK_DIV_HALF = 4,
    parameter int SAMPLE_W     = 16,
    parameter int SLOT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                bck,
    output logic                lrck,
    output logic                data,
    output logic                frame_start,
    output logic                underrun
);
    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int DIV_W      = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] LR_HI_FIRST = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] LR_HI_LAST  = BIT_W'(FRAME_BITS - 2);

    logic [DIV_W-1:0]      divCnt;
    logic [BIT_W-1:0]      bitCnt;
    logic                  bckQ, lrckQ, dataQ, frameStartQ, underrunQ;
    logic                  holdFull;
    logic [SAMPLE_W-1:0]   holdL, holdR;
    logic [FRAME_BITS-1:0] shFrame;
    logic [SAMPLE_W-1:0]   idleL, idleR;

    logic                  divTerm, fallEv, frameLoad, accept;
    logic [BIT_W-1:0]      bitNext, bitIdx;
    logic [SAMPLE_W-1:0]   loadL, loadR;
    logic [FRAME_BITS-1:0] loadVec;
    logic                  dataNext;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    logic [SAMPLE_W-1:0]   lastL, lastR;
    assign idleL = lastL;
    assign idleR = lastR;
`else
    assign idleL = '0;
    assign idleR = '0;
`endif

    assign divTerm   = enable && (divCnt == DIV_LAST);
    assign fallEv    = divTerm && bckQ;
    assign frameLoad = fallEv && (bitCnt == BIT_LAST);
    assign bitNext   = (bitCnt == BIT_LAST) ? '0 : bitCnt + BIT_W'(1);
    assign accept    = s_valid && !holdFull;
    // The load sees the pre-accept hold state: no same-cycle bypass.
    assign loadL     = holdFull ? holdL : idleL;
    assign loadR     = holdFull ? holdR : idleR;
    assign bitIdx    = BIT_LAST - bitNext;

    always_comb begin
        loadVec = '0;
        loadVec[FRAME_BITS-1 -: SAMPLE_W] = loadL;
        loadVec[SLOT_W-1 -: SAMPLE_W]     = loadR;
    end

    assign dataNext = frameLoad ? loadVec[FRAME_BITS-1] : shFrame[bitIdx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt      <= '0;
            bitCnt      <= BIT_LAST;
            bckQ        <= 1'b0;
            lrckQ       <= 1'b0;
            dataQ       <= 1'b0;
            frameStartQ <= 1'b0;
            underrunQ   <= 1'b0;
            holdFull    <= 1'b0;
            holdL       <= '0;
            holdR       <= '0;
            shFrame     <= '0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            lastL       <= '0;
            lastR       <= '0;
`endif
        end else begin
            frameStartQ <= 1'b0;
            underrunQ   <= 1'b0;
            if (accept) begin
                holdFull <= 1'b1;
                holdL    <= s_left;
                holdR    <= s_right;
            end else if (frameLoad && holdFull) begin
                holdFull <= 1'b0;
            end
            if (!enable) begin
                divCnt <= '0;
                bitCnt <= BIT_LAST;
                bckQ   <= 1'b0;
                lrckQ  <= 1'b0;
                dataQ  <= 1'b0;
            end else begin
                divCnt <= divTerm ? '0 : divCnt + DIV_W'(1);
                if (divTerm) begin
                    bckQ <= ~bckQ;
                end
                if (fallEv) begin
                    bitCnt <= bitNext;
                    lrckQ  <= (bitNext >= LR_HI_FIRST) && (bitNext <= LR_HI_LAST);
                    dataQ  <= dataNext;
                end
                if (frameLoad) begin
                    shFrame <= loadVec;
                    if (holdFull) begin
                        frameStartQ <= 1'b1;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
                        lastL       <= holdL;
                        lastR       <= holdR;
`endif
                    end else begin
                        underrunQ <= 1'b1;
                    end
                end
            end
        end
    end

    assign s_ready     = ~holdFull;
    assign bck         = bckQ;
    assign lrck        = lrckQ;
    assign data        = dataQ;
    assign frame_start = frameStartQ;
    assign underrun    = underrunQ;
endmodule
